// File: rtl/ir_cmd_pkg.sv
// Shared opcodes, remote key codes and scheduler FSM states for the IR command path.
package ir_cmd_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_INV  = 3'd3;
  localparam logic [2:0] OP_SWAP = 3'd4;

  localparam logic [7:0] KEY_SHR  = 8'h1B;
  localparam logic [7:0] KEY_SHL  = 8'h1F;
  localparam logic [7:0] KEY_INV  = 8'h1E;
  localparam logic [7:0] KEY_SWAP = 8'h0C;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Unmapped keys return OP_NOP so the caller can ignore them without flagging an error.
  function automatic logic [2:0] map_key(input logic [7:0] key);
    case (key)
      KEY_SHR:  map_key = OP_SHR;
      KEY_SHL:  map_key = OP_SHL;
      KEY_INV:  map_key = OP_INV;
      KEY_SWAP: map_key = OP_SWAP;
      default:  map_key = OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ir_cmd_scheduler_if.sv
// Decoder-side frame input, executor-side opcode handshake and scheduler status.
interface ir_cmd_scheduler_if #(
  parameter int DEPTH = 4
);
  logic                    ir_ready;
  logic [31:0]             ir_data;
  logic                    op_valid;
  logic [2:0]              op_code;
  logic                    op_ready;
  logic [$clog2(DEPTH):0]  fifo_level;
  logic [7:0]              drop_count;
  logic                    err_pulse;

  modport master (
    input  ir_ready, ir_data, op_ready,
    output op_valid, op_code, fifo_level, drop_count, err_pulse
  );

  modport slave (
    output ir_ready, ir_data, op_ready,
    input  op_valid, op_code, fifo_level, drop_count, err_pulse
  );
endinterface

// File: rtl/ir_cmd_fifo.sv
// Small synchronous opcode FIFO; a push into a full FIFO is taken when a pop happens the same cycle.
module ir_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_LVL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ir_cmd_scheduler.sv
// Validates IR frames, maps keys to LED opcodes, queues them and issues one at a time with a guard gap.
module ir_cmd_scheduler
  import ir_cmd_pkg::*;
#(
  parameter int         DEPTH      = 4,
  parameter int         GAP_CYCLES = 1000,
  parameter bit         ADDR_CHECK = 1'b0,
  parameter logic [7:0] ADDR       = 8'h00
) (
  input  logic clk,
  input  logic rst,
  ir_cmd_scheduler_if.master bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);

  logic             ready_d;
  logic             frame_edge;
  logic             frame_ok;
  logic [2:0]       frame_op;
  logic             push;
  logic             pop;
  logic             drop;
  logic             unused_mid_bits;

  logic [2:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;

  state_t           state, state_n;
  logic             op_valid_q, op_valid_n;
  logic [2:0]       op_code_q, op_code_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       drop_count_q;
  logic             err_pulse_q;

  // Frame stage: one evaluation per rising edge of the ready level.
  assign frame_edge      = bus.ir_ready & ~ready_d;
  assign frame_ok        = (bus.ir_data[31:24] == ~bus.ir_data[23:16]) &&
                           (!ADDR_CHECK || (bus.ir_data[7:0] == ADDR));
  assign frame_op        = map_key(bus.ir_data[23:16]);
  assign push            = frame_edge & frame_ok & (frame_op != OP_NOP);
  assign drop            = push & fifo_full & ~pop;
  assign unused_mid_bits = ^bus.ir_data[15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_d      <= 1'b0;
      err_pulse_q  <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      ready_d     <= bus.ir_ready;
      err_pulse_q <= frame_edge & ~frame_ok;
      if (drop && (drop_count_q != 8'hFF)) drop_count_q <= drop_count_q + 8'd1;
    end
  end

  ir_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (3)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (frame_op),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Issue stage: pop into the output register, hold until accepted, then enforce the gap.
  always_comb begin
    state_n    = state;
    op_valid_n = op_valid_q;
    op_code_n  = op_code_q;
    cnt_n      = cnt;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          op_valid_n = 1'b1;
          op_code_n  = fifo_dout;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        if (op_valid_q && bus.op_ready) begin
          op_valid_n = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_n = IDLE;
          end else begin
            state_n = GAP;
            cnt_n   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        cnt_n = cnt - 1'b1;
        // Leaving as the count steps down to 1 puts the next rise GAP_CYCLES+1 after the handshake.
        if (int'(cnt) <= 2) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_valid_q <= 1'b0;
      op_code_q  <= OP_NOP;
      cnt        <= '0;
    end else begin
      state      <= state_n;
      op_valid_q <= op_valid_n;
      op_code_q  <= op_code_n;
      cnt        <= cnt_n;
    end
  end

  assign bus.op_valid   = op_valid_q;
  assign bus.op_code    = op_code_q;
  assign bus.fifo_level = fifo_level;
  assign bus.drop_count = drop_count_q;
  assign bus.err_pulse  = err_pulse_q;

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// Directed and randomized checks of ir_cmd_scheduler against a queue-based reference model.
module tb_ir_cmd_scheduler;

  localparam int         DEPTH = 4;
  localparam int         GAP   = 5;
  localparam logic [7:0] ADDR  = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ir_cmd_scheduler_if #(.DEPTH(DEPTH)) bus ();

  ir_cmd_scheduler #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP),
    .ADDR_CHECK (1'b1),
    .ADDR       (ADDR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: pending queue, issued slot, guard-gap countdown, counters.
  int q[$];
  bit m_valid;
  int m_code;
  int m_drop;
  bit m_err;
  bit m_prev;
  int m_wait;

  int dut_hs[$];
  int cyc_n = 0;
  int last_hs = -1;
  bit prev_obs_valid = 1'b0;

  function automatic int key_op(input logic [7:0] k);
    case (k)
      8'h1B:   return 1;
      8'h1F:   return 2;
      8'h1E:   return 3;
      8'h0C:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] frame(input logic [7:0] k, input logic [7:0] a);
    return {~k, k, 8'h00, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit rise, pass, push, pop, full, hs;
    int op;
    if (rst) begin
      q.delete();
      m_valid = 0; m_code = 0; m_drop = 0; m_err = 0; m_prev = 0; m_wait = 0;
      last_hs = -1;
      return;
    end
    rise = bus.ir_ready && !m_prev;
    pass = (bus.ir_data[31:24] == ~bus.ir_data[23:16]) && (bus.ir_data[7:0] == ADDR);
    op   = key_op(bus.ir_data[23:16]);
    push = rise && pass && (op != 0);
    hs   = m_valid && bus.op_ready;
    pop  = !m_valid && (m_wait == 0) && (q.size() > 0);
    full = (q.size() == DEPTH);
    m_err  = rise && !pass;
    m_prev = bus.ir_ready;
    if (hs) begin
      m_valid = 0;
      m_wait  = GAP - 1;
    end else if (m_wait > 0) begin
      m_wait--;
    end
    if (pop) begin
      m_code  = q.pop_front();
      m_valid = 1;
    end
    if (push) begin
      if (!full || pop) q.push_back(op);
      else if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic cyc();
    if (!rst && bus.op_valid === 1'b1 && bus.op_ready === 1'b1) begin
      dut_hs.push_back(int'(bus.op_code));
      last_hs = cyc_n;
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    check("op_valid", bus.op_valid, m_valid);
    if (m_valid) check("op_code", bus.op_code, m_code);
    check("fifo_level", bus.fifo_level, q.size());
    check("drop_count", bus.drop_count, m_drop);
    check("err_pulse", bus.err_pulse, m_err);
    if (bus.op_valid === 1'b1 && !prev_obs_valid && last_hs >= 0) begin
      total++;
      assert (cyc_n - last_hs >= GAP + 1)
      else begin
        bad++;
        $error("FAIL issue_spacing: observed=%0d expected>=%0d", cyc_n - last_hs, GAP + 1);
      end
    end
    prev_obs_valid = (bus.op_valid === 1'b1);
  endtask

  task automatic send(input logic [31:0] d);
    bus.ir_data  = d;
    bus.ir_ready = 1'b1;
    cyc();
    bus.ir_ready = 1'b0;
    cyc();
  endtask

  initial begin
    int base;
    int n;
    int exp_order[5];
    logic [7:0] keys[4];
    logic [7:0] k;
    keys = '{8'h1B, 8'h1F, 8'h1E, 8'h0C};
    exp_order = '{1, 2, 3, 4, 1};

    bus.ir_ready = 1'b0;
    bus.ir_data  = 32'h0;
    bus.op_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_op_valid", bus.op_valid, 0);
    check("rst_op_code", bus.op_code, 0);
    check("rst_level", bus.fifo_level, 0);
    check("rst_drop", bus.drop_count, 0);
    check("rst_err", bus.err_pulse, 0);
    repeat (3) cyc();

    // Single command: op_valid two cycles after the edge cycle, for one cycle
    bus.op_ready = 1'b1;
    bus.ir_data  = 32'hE41B_0000;
    bus.ir_ready = 1'b1;
    cyc();
    check("single_t1_valid", bus.op_valid, 0);
    check("single_t1_level", bus.fifo_level, 1);
    bus.ir_ready = 1'b0;
    cyc();
    check("single_t2_valid", bus.op_valid, 1);
    check("single_t2_code", bus.op_code, 1);
    check("single_t2_level", bus.fifo_level, 0);
    cyc();
    check("single_t3_valid", bus.op_valid, 0);
    repeat (10) cyc();

    // Bad complement
    bus.ir_data  = 32'h001B_0000;
    bus.ir_ready = 1'b1;
    cyc();
    check("badcmp_err", bus.err_pulse, 1);
    bus.ir_ready = 1'b0;
    cyc();
    check("badcmp_err_clear", bus.err_pulse, 0);
    repeat (3) cyc();
    check("badcmp_valid", bus.op_valid, 0);
    check("badcmp_level", bus.fifo_level, 0);

    // Unmapped key passes the check but is ignored
    bus.ir_data  = 32'hFD02_0000;
    bus.ir_ready = 1'b1;
    cyc();
    check("unmapped_err", bus.err_pulse, 0);
    bus.ir_ready = 1'b0;
    repeat (3) cyc();
    check("unmapped_valid", bus.op_valid, 0);

    // Wrong address with address checking enabled
    bus.ir_data  = 32'hE41B_0055;
    bus.ir_ready = 1'b1;
    cyc();
    check("addr_err", bus.err_pulse, 1);
    bus.ir_ready = 1'b0;
    repeat (10) cyc();

    // Overflow with executor stalled: one op held, DEPTH queued, the rest dropped
    bus.op_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(frame(keys[i % 4], ADDR));
    check("ovf_level", bus.fifo_level, DEPTH);
    check("ovf_drop", bus.drop_count, 2);
    check("ovf_held_valid", bus.op_valid, 1);
    check("ovf_held_code", bus.op_code, 1);
    repeat (20) cyc();
    check("ovf_still_held", bus.op_code, 1);
    base = dut_hs.size();
    bus.op_ready = 1'b1;
    n = 0;
    while (dut_hs.size() < base + 5 && n < 200) begin
      cyc();
      n++;
    end
    check("ovf_drain_count", dut_hs.size() - base, 5);
    for (int i = 0; i < 5; i++)
      if (base + i < dut_hs.size()) check("ovf_order", dut_hs[base + i], exp_order[i]);
    repeat (10) cyc();
    check("ovf_level_empty", bus.fifo_level, 0);

    // Level held high for 100 cycles yields exactly one command
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    base = dut_hs.size();
    bus.op_ready = 1'b1;
    bus.ir_data  = frame(8'h1F, ADDR);
    bus.ir_ready = 1'b1;
    repeat (100) cyc();
    bus.ir_ready = 1'b0;
    repeat (10) cyc();
    check("held_one_push", dut_hs.size() - base, 1);

    // Guard gap: second op rises GAP+1 cycles after the first handshake cycle
    bus.op_ready = 1'b0;
    send(frame(8'h1E, ADDR));
    send(frame(8'h0C, ADDR));
    n = 0;
    while (bus.op_valid !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    check("gap_first_valid", bus.op_valid, 1);
    bus.op_ready = 1'b1;
    cyc();
    bus.op_ready = 1'b0;
    n = 1;
    while (bus.op_valid !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    check("gap_rise_delay", n, GAP + 1);
    check("gap_second_code", bus.op_code, 4);
    bus.op_ready = 1'b1;
    repeat (10) cyc();

    // Reset while an op is offered and two are queued
    bus.op_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(frame(keys[i], ADDR));
    check("midrst_pre_valid", bus.op_valid, 1);
    check("midrst_pre_level", bus.fifo_level, 2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_valid", bus.op_valid, 0);
    check("midrst_level", bus.fifo_level, 0);
    check("midrst_drop", bus.drop_count, 0);
    base = dut_hs.size();
    bus.op_ready = 1'b1;
    repeat (30) cyc();
    check("midrst_no_reissue", dut_hs.size() - base, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if (bus.ir_ready === 1'b0) begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: bus.ir_data = frame(keys[$urandom_range(0, 3)], ADDR);
            6: begin
              k = 8'($urandom);
              bus.ir_data = {k, k, 16'h0000};
            end
            7: bus.ir_data = frame(8'h02 + 8'($urandom_range(0, 7)), ADDR);
            8: bus.ir_data = frame(keys[$urandom_range(0, 3)], 8'h01 + 8'($urandom_range(0, 200)));
            default: bus.ir_data = $urandom;
          endcase
          bus.ir_ready = 1'b1;
        end else begin
          bus.ir_ready = 1'b0;
        end
      end
      bus.op_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    bus.ir_ready = 1'b0;
    bus.op_ready = 1'b1;
    repeat (60) cyc();
    check("final_level", bus.fifo_level, 0);
    check("final_valid", bus.op_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
